// File: rtl/regfile_pkg.sv
// Shared types and sizing for the register file write-back path.
package regfile_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned DATA_W   = 32;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_ALU    = 2'd1,
    SRC_QUEUE  = 2'd2,
    SRC_DIRECT = 2'd3
  } wb_src_e;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_queue.sv
// Small synchronous FIFO holding load results that lost write-port arbitration.
module wb_load_queue
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  wb_entry_t                  i_push_data,
  input  logic                       i_pop,
  output wb_entry_t                  o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/register_writeback.sv
// Merges ALU and load results onto the register file write port and tracks pending loads.
module register_writeback
  import regfile_pkg::*;
#(
  parameter int unsigned LQ_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_alu_valid,
  input  logic [REG_W-1:0]    i_alu_rd,
  input  logic [DATA_W-1:0]   i_alu_data,
  input  logic                i_load_valid,
  input  logic [REG_W-1:0]    i_load_rd,
  input  logic [DATA_W-1:0]   i_load_data,
  output logic                o_load_ready,
  input  logic                i_issue_valid,
  input  logic [REG_W-1:0]    i_issue_rd,
  output logic [NUM_REGS-1:0] o_busy,
  output logic                o_we,
  output logic [REG_W-1:0]    o_ws,
  output logic [DATA_W-1:0]   o_wd,
  output logic                o_hazard_err
);

  localparam int unsigned CNT_W = $clog2(LQ_DEPTH) + 1;

  logic                r_we;
  logic                r_we_load;
  logic [REG_W-1:0]    r_ws;
  logic [DATA_W-1:0]   r_wd;
  logic [NUM_REGS-1:0] r_busy;
  logic                r_hazard_err;

  wb_src_e             w_sel;
  wb_entry_t           w_wr_entry;
  wb_entry_t           w_load_entry;
  wb_entry_t           w_q_head;
  logic                w_q_full;
  logic                w_q_empty;
  logic [CNT_W-1:0]    w_q_count;
  logic                w_load_fire;
  logic                w_push;
  logic                w_pop;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_hazard_nxt;

  // Ready depends only on reset and the registered queue occupancy.
  assign o_load_ready = !i_reset && !w_q_full;
  assign w_load_fire  = i_load_valid && o_load_ready;
  assign w_load_entry = '{rd: i_load_rd, data: i_load_data};

  assign w_push = w_load_fire && (w_sel != SRC_DIRECT);
  assign w_pop  = (w_sel == SRC_QUEUE);

  wb_load_queue #(
    .DEPTH (LQ_DEPTH)
  ) u_load_queue (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (w_push),
    .i_push_data (w_load_entry),
    .i_pop       (w_pop),
    .o_head      (w_q_head),
    .o_full      (w_q_full),
    .o_empty     (w_q_empty),
    .o_count     (w_q_count)
  );

  // Source priority: ALU, then oldest queued load, then a load that bypasses the queue.
  always_comb begin
    w_sel      = SRC_NONE;
    w_wr_entry = '{rd: i_alu_rd, data: i_alu_data};
    if (i_alu_valid) begin
      w_sel = SRC_ALU;
    end else if (!w_q_empty) begin
      w_sel      = SRC_QUEUE;
      w_wr_entry = w_q_head;
    end else if (w_load_fire) begin
      w_sel      = SRC_DIRECT;
      w_wr_entry = w_load_entry;
    end
  end

  // Clear follows the load write on the port; a same-cycle issue to that register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_we && r_we_load) begin
      w_busy_nxt[r_ws] = 1'b0;
    end
    if (i_issue_valid) begin
      w_busy_nxt[i_issue_rd] = 1'b1;
    end
  end

  always_comb begin
    w_hazard_nxt = r_hazard_err;
    if (i_alu_valid && r_busy[i_alu_rd]) begin
      w_hazard_nxt = 1'b1;
    end
    if (i_issue_valid && r_busy[i_issue_rd]) begin
      w_hazard_nxt = 1'b1;
    end
    if (w_load_fire && !r_busy[i_load_rd]) begin
      w_hazard_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_we         <= 1'b0;
      r_we_load    <= 1'b0;
      r_ws         <= '0;
      r_wd         <= '0;
      r_busy       <= '0;
      r_hazard_err <= 1'b0;
    end else begin
      r_we         <= (w_sel != SRC_NONE);
      r_we_load    <= (w_sel == SRC_QUEUE) || (w_sel == SRC_DIRECT);
      if (w_sel != SRC_NONE) begin
        r_ws <= w_wr_entry.rd;
        r_wd <= w_wr_entry.data;
      end
      r_busy       <= w_busy_nxt;
      r_hazard_err <= w_hazard_nxt;
    end
  end

  assert property (@(posedge i_clk) disable iff (i_reset) w_q_count <= CNT_W'(LQ_DEPTH));

  assign o_we         = r_we;
  assign o_ws         = r_ws;
  assign o_wd         = r_wd;
  assign o_busy       = r_busy;
  assign o_hazard_err = r_hazard_err;

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback with hand-computed expected values.
module tb_register_writeback;
  import regfile_pkg::*;

  logic                clk;
  logic                reset;
  logic                alu_valid;
  logic [REG_W-1:0]    alu_rd;
  logic [DATA_W-1:0]   alu_data;
  logic                load_valid;
  logic [REG_W-1:0]    load_rd;
  logic [DATA_W-1:0]   load_data;
  logic                load_ready;
  logic                issue_valid;
  logic [REG_W-1:0]    issue_rd;
  logic [NUM_REGS-1:0] busy;
  logic                we;
  logic [REG_W-1:0]    ws;
  logic [DATA_W-1:0]   wd;
  logic                hazard_err;

  int n_checks = 0;
  int n_errors = 0;

  register_writeback #(
    .LQ_DEPTH (4)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_alu_valid  (alu_valid),
    .i_alu_rd     (alu_rd),
    .i_alu_data   (alu_data),
    .i_load_valid (load_valid),
    .i_load_rd    (load_rd),
    .i_load_data  (load_data),
    .o_load_ready (load_ready),
    .i_issue_valid(issue_valid),
    .i_issue_rd   (issue_rd),
    .o_busy       (busy),
    .o_we         (we),
    .o_ws         (ws),
    .o_wd         (wd),
    .o_hazard_err (hazard_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [REG_W-1:0] rd, input logic [31:0] data);
    check({tag, ".we"}, 32'(we), 32'd1);
    check({tag, ".ws"}, 32'(ws), 32'(rd));
    check({tag, ".wd"}, wd, data);
  endtask

  task automatic issue(input logic [REG_W-1:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
    step();
    issue_valid = 1'b0;
  endtask

  logic [REG_W-1:0]  ld_rd   [4];
  logic [DATA_W-1:0] ld_data [4];

  initial begin
    reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    load_valid = 1'b0; load_rd = '0; load_data = '0;
    issue_valid = 1'b0; issue_rd = '0;

    // Reset, then idle
    step();
    check("rst.ready_in_reset", 32'(load_ready), 32'd0);
    step();
    reset = 1'b0;
    step(); step();
    check("rst.we", 32'(we), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.ready", 32'(load_ready), 32'd1);
    check("rst.hazard", 32'(hazard_err), 32'd0);

    // ALU only
    alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    check_write("alu", 4'd3, 32'hDEADBEEF);
    check("alu.busy", 32'(busy), 32'd0);
    step();
    check("alu.idle_we", 32'(we), 32'd0);
    check("alu.hold_ws", 32'(ws), 32'd3);
    check("alu.hold_wd", wd, 32'hDEADBEEF);

    // Direct load path
    issue(4'd5);
    check("dir.busy_set", 32'(busy), 32'h0020);
    step(); step();
    load_valid = 1'b1; load_rd = 4'd5; load_data = 32'h1234;
    check("dir.ready", 32'(load_ready), 32'd1);
    step();
    load_valid = 1'b0;
    check_write("dir", 4'd5, 32'h1234);
    check("dir.busy_during_write", 32'(busy), 32'h0020);
    step();
    check("dir.busy_clear", 32'(busy), 32'h0000);
    check("dir.we_off", 32'(we), 32'd0);

    // Contention: loads queue behind six ALU writes, then drain in order
    ld_rd[0] = 4'd1; ld_data[0] = 32'h1111_0001;
    ld_rd[1] = 4'd2; ld_data[1] = 32'h2222_0002;
    ld_rd[2] = 4'd7; ld_data[2] = 32'h7777_0007;
    issue(4'd1); issue(4'd2); issue(4'd7);
    check("cnt.busy", 32'(busy), 32'h0086);
    for (int k = 0; k < 6; k++) begin
      alu_valid = 1'b1; alu_rd = 4'd10; alu_data = 32'hA0 + 32'(k);
      if (k < 3) begin
        load_valid = 1'b1; load_rd = ld_rd[k]; load_data = ld_data[k];
        check($sformatf("cnt.ready%0d", k), 32'(load_ready), 32'd1);
      end else begin
        load_valid = 1'b0;
      end
      step();
      check_write($sformatf("cnt.alu%0d", k), 4'd10, 32'hA0 + 32'(k));
    end
    alu_valid = 1'b0; load_valid = 1'b0;
    check("cnt.busy_queued", 32'(busy), 32'h0086);
    step();
    check_write("cnt.ld1", 4'd1, 32'h1111_0001);
    check("cnt.busy_a", 32'(busy), 32'h0086);
    step();
    check_write("cnt.ld2", 4'd2, 32'h2222_0002);
    check("cnt.busy_b", 32'(busy), 32'h0084);
    step();
    check_write("cnt.ld7", 4'd7, 32'h7777_0007);
    check("cnt.busy_c", 32'(busy), 32'h0080);
    step();
    check("cnt.we_off", 32'(we), 32'd0);
    check("cnt.busy_d", 32'(busy), 32'h0000);
    check("cnt.hazard", 32'(hazard_err), 32'd0);

    // Full queue: four loads fill it, the fifth waits for the first pop
    issue(4'd1); issue(4'd2); issue(4'd3); issue(4'd4); issue(4'd6);
    check("full.busy", 32'(busy), 32'h005E);
    alu_valid = 1'b1; alu_rd = 4'd10; alu_data = 32'h55;
    for (int k = 0; k < 4; k++) begin
      load_valid = 1'b1; load_rd = 4'(k + 1); load_data = 32'hF000 + 32'(k + 1);
      step();
    end
    load_rd = 4'd6; load_data = 32'hF006;
    check("full.ready0", 32'(load_ready), 32'd0);
    step();
    check("full.ready1", 32'(load_ready), 32'd0);
    alu_valid = 1'b0;
    step();
    check_write("full.ld1", 4'd1, 32'hF001);
    check("full.ready_after_pop", 32'(load_ready), 32'd1);
    step();
    load_valid = 1'b0;
    check_write("full.ld2", 4'd2, 32'hF002);
    step();
    check_write("full.ld3", 4'd3, 32'hF003);
    step();
    check_write("full.ld4", 4'd4, 32'hF004);
    step();
    check_write("full.ld6", 4'd6, 32'hF006);
    step();
    check("full.we_off", 32'(we), 32'd0);
    step();
    check("full.busy_clear", 32'(busy), 32'h0000);
    check("full.hazard", 32'(hazard_err), 32'd0);

    // WAW hazard: ALU writes a register with a pending load
    issue(4'd5);
    alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 32'hBAD5;
    step();
    alu_valid = 1'b0;
    check("haz.flag", 32'(hazard_err), 32'd1);
    check_write("haz.alu", 4'd5, 32'hBAD5);
    check("haz.busy_kept", 32'(busy), 32'h0020);
    step();
    check("haz.held", 32'(hazard_err), 32'd1);

    // Reset with two loads queued drops them
    issue(4'd8); issue(4'd9);
    alu_valid = 1'b1; alu_rd = 4'd11; alu_data = 32'hCC;
    load_valid = 1'b1; load_rd = 4'd8; load_data = 32'h8888;
    step();
    load_rd = 4'd9; load_data = 32'h9999;
    step();
    alu_valid = 1'b0; load_valid = 1'b0;
    reset = 1'b1;
    step();
    check("mrst.we", 32'(we), 32'd0);
    check("mrst.busy", 32'(busy), 32'h0000);
    check("mrst.hazard", 32'(hazard_err), 32'd0);
    check("mrst.ready", 32'(load_ready), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("mrst.nowrite%0d", k), 32'(we), 32'd0);
    end
    check("mrst.ready_after", 32'(load_ready), 32'd1);

    // Load for a register with no outstanding issue is flagged but still written
    load_valid = 1'b1; load_rd = 4'd12; load_data = 32'hC0C0;
    step();
    load_valid = 1'b0;
    check("orph.hazard", 32'(hazard_err), 32'd1);
    check_write("orph", 4'd12, 32'hC0C0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
